// File: rtl/fwd_source_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types for the pipeline back-end (EX/MEM, MEM/WB, MEM-stage access).
//   XLEN_DEF / RA_W_DEF : default datapath and register-address widths; the
//                         pipe-register structs are sized with these.
//   mem_state_t         : MEM-stage access FSM states.
//   ex_mem_t / mem_wb_t : pipe-register layouts.
//   wb_flag()           : write-back qualifier shared by both registers.
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                valid;
    logic [RA_W_DEF-1:0] rd;
    logic                wb;
    logic                memread;
    logic                memwrite;
    logic [XLEN_DEF-1:0] alu;
    logic [XLEN_DEF-1:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic [RA_W_DEF-1:0] rd;
    logic                wb;
    logic [XLEN_DEF-1:0] data;
  } mem_wb_t;

  // x0 is hard-wired to zero, so a write to it must never look like a
  // write-back to the forwarding unit.
  function automatic logic wb_flag(input logic                valid,
                                   input logic                regwrite,
                                   input logic [RA_W_DEF-1:0] rd);
    return valid & regwrite & (rd != '0);
  endfunction

endpackage

// File: rtl/fwd_source_pipe_if.sv
// -----------------------------------------------------------------------------
// fwd_source_pipe_if
// Data-memory handshake bundle of the MEM stage.
//   mem_req / mem_we / mem_addr / mem_wdata : request, driven by the master
//   mem_ready / mem_rdata                   : response, driven by the slave
//   stall                                   : mem_req & ~mem_ready
// Handshake: a request is outstanding while mem_req=1; it completes on the
// first rising edge where mem_ready=1 is seen with it. Until then the master
// keeps mem_we/mem_addr/mem_wdata stable. mem_rdata is only meaningful in
// the completing cycle.
// -----------------------------------------------------------------------------
interface fwd_source_pipe_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  logic            stall;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, stall,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, stall,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/fwd_source_pipe_mem_access.sv
// -----------------------------------------------------------------------------
// mem_access_fsm
// MEM-stage data-memory access controller.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   access_i        : EX/MEM holds a valid load or store
//   we_i            : EX/MEM entry is a store
//   addr_i, wdata_i : EX/MEM address (ALU result) and store data
//   state_o         : current FSM state (debug visibility)
//   bus             : memory handshake (master side) and stall
// The EX/MEM register is frozen while stall is high, so address/data held on
// the bus during MEM_WAIT are stable by construction.
// -----------------------------------------------------------------------------
module mem_access_fsm
  import fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                access_i,
  input  logic                we_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output mem_state_t          state_o,
  fwd_source_pipe_if.master   bus
);

  mem_state_t r_state;
  mem_state_t w_next;
  logic       w_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (access_i) begin
          w_req = 1'b1;
          if (!bus.mem_ready) w_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        w_req = 1'b1;
        if (bus.mem_ready) w_next = MEM_IDLE;
      end
      default: w_next = MEM_IDLE;
    endcase
  end

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = we_i;
  assign bus.mem_addr  = addr_i;
  assign bus.mem_wdata = wdata_i;
  assign bus.stall     = w_req & ~bus.mem_ready;
  assign state_o       = r_state;

endmodule

// File: rtl/fwd_source_pipe.sv
// -----------------------------------------------------------------------------
// fwd_source_pipe
// Back end of the 5-stage core: EX/MEM and MEM/WB pipe registers plus the
// MEM-stage data-memory handshake. Supplies rd/wb/data of both registers to
// the forwarding unit and raises the memory-wait stall and load-use hazard.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   ex_*_i                  : instruction leaving EX
//   id_rs1_i, id_rs2_i      : ID-stage sources (load-use detection)
//   flush_i                 : bubble the instruction entering EX/MEM
//   mem_*_o / mem_*_i       : data-memory request / response
//   ex_mem_*_o, mem_wb_*_o  : forwarding sources; mem_wb_wb_o is the RF write
//   stall_o                 : freeze IF/ID/EX while memory is not ready
//   load_use_o              : load-use hazard (insert one bubble)
// Build option: FWD_LOAD_USE_EN -- when defined, load_use_o is computed in
// hardware; otherwise it is tied low and the compiler schedules the bubble.
// XLEN/RA_W must match fwd_pkg::XLEN_DEF/RA_W_DEF (the pipe structs use them).
// -----------------------------------------------------------------------------
module fwd_source_pipe
  import fwd_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memread_i,
  input  logic            ex_memwrite_i,
  input  logic [XLEN-1:0] ex_alu_i,
  input  logic [XLEN-1:0] ex_sdata_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ready_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [RA_W-1:0] ex_mem_rrd_o,
  output logic            ex_mem_wb_o,
  output logic [XLEN-1:0] ex_mem_data_o,
  output logic [RA_W-1:0] mem_wb_rrd_o,
  output logic            mem_wb_wb_o,
  output logic [XLEN-1:0] mem_wb_data_o,
  output logic            stall_o,
  output logic            load_use_o
);

  fwd_source_pipe_if #(.XLEN(XLEN)) u_bus ();

  ex_mem_t    r_ex_mem;
  mem_wb_t    r_mem_wb;
  mem_state_t w_mem_state;
  logic       w_ex_live;
  logic       w_mem_access;

  // A flushed or invalid EX slot enters EX/MEM as a bubble. While stalled
  // the whole register holds, which also makes flush_i a don't-care.
  assign w_ex_live    = ex_valid_i & ~flush_i;
  assign w_mem_access = r_ex_mem.valid & (r_ex_mem.memread | r_ex_mem.memwrite);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_mem <= '0;
    end else if (!u_bus.stall) begin
      r_ex_mem.valid    <= w_ex_live;
      r_ex_mem.rd       <= ex_rd_i;
      r_ex_mem.wb       <= wb_flag(w_ex_live, ex_regwrite_i, ex_rd_i);
      r_ex_mem.memread  <= w_ex_live & ex_memread_i;
      r_ex_mem.memwrite <= w_ex_live & ex_memwrite_i;
      r_ex_mem.alu      <= ex_alu_i;
      r_ex_mem.sdata    <= ex_sdata_i;
    end
  end

  mem_access_fsm #(.XLEN(XLEN)) u_mem_fsm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .access_i (w_mem_access),
    .we_i     (r_ex_mem.memwrite),
    .addr_i   (r_ex_mem.alu),
    .wdata_i  (r_ex_mem.sdata),
    .state_o  (w_mem_state),
    .bus      (u_bus.master)
  );

  assign u_bus.mem_ready = mem_ready_i;
  assign u_bus.mem_rdata = mem_rdata_i;

  // MEM/WB advances every cycle; a memory wait turns into a bubble so the
  // instruction already in MEM/WB retires while the load/store stays in MEM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_wb <= '0;
    end else if (u_bus.stall) begin
      r_mem_wb <= '0;
    end else begin
      r_mem_wb.rd   <= r_ex_mem.rd;
      r_mem_wb.wb   <= r_ex_mem.wb & ~r_ex_mem.memwrite;
      r_mem_wb.data <= r_ex_mem.memread ? u_bus.mem_rdata : r_ex_mem.alu;
    end
  end

  assign mem_req_o     = u_bus.mem_req;
  assign mem_we_o      = u_bus.mem_we;
  assign mem_addr_o    = u_bus.mem_addr;
  assign mem_wdata_o   = u_bus.mem_wdata;
  assign stall_o       = u_bus.stall;

  // Load data does not exist yet in EX/MEM, so a load never forwards from it.
  assign ex_mem_rrd_o  = r_ex_mem.rd;
  assign ex_mem_wb_o   = r_ex_mem.wb & ~r_ex_mem.memread;
  assign ex_mem_data_o = r_ex_mem.alu;

  assign mem_wb_rrd_o  = r_mem_wb.rd;
  assign mem_wb_wb_o   = r_mem_wb.wb;
  assign mem_wb_data_o = r_mem_wb.data;

`ifdef FWD_LOAD_USE_EN
  assign load_use_o = ex_valid_i & ex_memread_i & (ex_rd_i != '0) &
                      ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
`else
  logic w_unused_ids;
  assign w_unused_ids = ^{id_rs1_i, id_rs2_i};
  assign load_use_o   = 1'b0;
`endif

  // The wait state only exists while a request is outstanding.
  a_wait_holds_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (w_mem_state == MEM_WAIT) |-> u_bus.mem_req
  );

endmodule
